// File: rtl/imem_load_ctrl_if.sv
// Loader-to-controller word stream: valid/ready handshake carrying one instruction word per beat.
interface imem_load_ctrl_if #(
    parameter int Width = 32
);
    logic             ld_valid;
    logic [Width-1:0] ld_data;
    logic             ld_ready;

    modport master (output ld_valid, output ld_data, input ld_ready);
    modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory sequencer: holds the core while a program streams into consecutive words
// from address 0, then hands the memory read port over to fetch.
module imem_load_ctrl #(
    parameter int               Depth    = 128,
    parameter int               Width    = 32,
    parameter int               AddrW    = $clog2(Depth) + 2,
    parameter logic [Width-1:0] NopInstr = Width'(32'h00000013)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_start,
    input  logic [$clog2(Depth):0]     load_len,
    input  logic                       run_go,
    imem_load_ctrl_if.slave            loader,
    input  logic [AddrW-1:0]           fetch_addr,
    output logic [Width-1:0]           fetch_instr,
    output logic                       core_hold,
    output logic                       mem_we0,
    output logic [AddrW-1:0]           mem_wr_addr0,
    output logic [Width-1:0]           mem_wr_din0,
    output logic [AddrW-1:0]           mem_rd_addr0,
    input  logic [Width-1:0]           mem_rd_dout0,
    output logic                       load_done,
    output logic                       load_err,
    output logic [$clog2(Depth):0]     words_loaded
);

    localparam int IdxW = $clog2(Depth);
    localparam int LenW = IdxW + 1;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [LenW-1:0] cnt;
    logic [LenW-1:0] len;
    logic            len_legal;
    logic            start_req;
    logic            start_ok;
    logic            accept;
    logic            last_word;

    // Load requests are only honoured outside LOAD; an illegal length is reported and dropped.
    assign len_legal = (load_len != '0) && (load_len <= LenW'(Depth));
    assign start_req = load_start && (state != LOAD);
    assign start_ok  = start_req && len_legal;
    assign accept    = (state == LOAD) && loader.ld_valid;
    assign last_word = accept && (cnt == len - LenW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            HOLD: begin
                if (start_ok) begin
                    state_next = LOAD;
                end else if (run_go) begin
                    state_next = RUN;
                end
            end
            LOAD: begin
                if (last_word) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (start_ok) begin
                    state_next = LOAD;
                end
            end
            default: state_next = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            len          <= '0;
            words_loaded <= '0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            load_done <= last_word;
            load_err  <= start_req && !len_legal;
            if (start_ok) begin
                len          <= load_len;
                cnt          <= '0;
                words_loaded <= '0;
            end else if (accept) begin
                cnt          <= cnt + LenW'(1);
                words_loaded <= words_loaded + LenW'(1);
            end
        end
    end

    // Write port is driven only while loading; otherwise it is parked at zero.
    always_comb begin
        core_hold       = (state != RUN);
        loader.ld_ready = (state == LOAD);
        mem_we0         = loader.ld_valid && (state == LOAD);
        mem_wr_addr0    = '0;
        mem_wr_din0     = '0;
        if (state == LOAD) begin
            mem_wr_addr0 = AddrW'({cnt[IdxW-1:0], 2'b00});
            mem_wr_din0  = loader.ld_data;
        end
        mem_rd_addr0 = fetch_addr;
        fetch_instr  = (state == RUN) ? mem_rd_dout0 : NopInstr;
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a negedge-written memory model and a write log.
module tb_imem_load_ctrl;

    localparam int Depth = 128;
    localparam int Width = 32;
    localparam int AddrW = 9;
    localparam int LenW  = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_start;
    logic [LenW-1:0]  load_len;
    logic             run_go;
    logic [AddrW-1:0] fetch_addr;
    logic [Width-1:0] fetch_instr;
    logic             core_hold;
    logic             mem_we0;
    logic [AddrW-1:0] mem_wr_addr0;
    logic [Width-1:0] mem_wr_din0;
    logic [AddrW-1:0] mem_rd_addr0;
    logic [Width-1:0] mem_rd_dout0;
    logic             load_done;
    logic             load_err;
    logic [LenW-1:0]  words_loaded;

    int total = 0;
    int bad   = 0;

    logic [Width-1:0] mem [0:Depth-1];
    logic [AddrW-1:0] wr_addr_q [$];
    logic [Width-1:0] wr_data_q [$];

    imem_load_ctrl_if #(.Width(Width)) ld_bus ();

    imem_load_ctrl #(.Depth(Depth), .Width(Width)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_len     (load_len),
        .run_go       (run_go),
        .loader       (ld_bus.slave),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .core_hold    (core_hold),
        .mem_we0      (mem_we0),
        .mem_wr_addr0 (mem_wr_addr0),
        .mem_wr_din0  (mem_wr_din0),
        .mem_rd_addr0 (mem_rd_addr0),
        .mem_rd_dout0 (mem_rd_dout0),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Inputs are stable at the falling edge, so that is where the write the DUT commits is captured.
    always @(negedge clk) begin
        if (mem_we0) begin
            mem[mem_wr_addr0[AddrW-1:2]] = mem_wr_din0;
            wr_addr_q.push_back(mem_wr_addr0);
            wr_data_q.push_back(mem_wr_din0);
        end
    end

    assign mem_rd_dout0 = mem[mem_rd_addr0[AddrW-1:2]];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ls, input logic [LenW-1:0] len, input logic rg,
                                 input logic v, input logic [Width-1:0] d);
        load_start      = ls;
        load_len        = len;
        run_go          = rg;
        ld_bus.ld_valid = v;
        ld_bus.ld_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fetchCheck(input string tag, input logic [AddrW-1:0] a, input logic [31:0] exp);
        fetch_addr = a;
        #1;
        checkOutput(tag, fetch_instr, exp);
    endtask

    logic [AddrW-1:0] exp_addr4 [4];
    logic             pat_valid [6];
    int               done_cnt;

    initial begin
        for (int i = 0; i < Depth; i++) mem[i] = 32'hDEAD0000 + i;
        exp_addr4 = '{9'h000, 9'h004, 9'h008, 9'h00C};
        pat_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        reset      = 1'b1;
        fetch_addr = '0;
        applyStimulus(0, 8'd0, 0, 0, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) tick();
        checkOutput("rst_hold",  core_hold, 1);
        checkOutput("rst_ready", ld_bus.ld_ready, 0);
        checkOutput("rst_we",    mem_we0, 0);
        checkOutput("rst_done",  load_done, 0);
        checkOutput("rst_err",   load_err, 0);
        checkOutput("rst_words", words_loaded, 0);
        fetchCheck("rst_nop0", 9'h010, 32'h00000013);
        fetchCheck("rst_nop1", 9'h008, 32'h00000013);

        // Four-word back-to-back load from HOLD.
        applyStimulus(1, 8'd4, 0, 0, 32'h0);
        tick();
        applyStimulus(0, 8'd0, 0, 0, 32'h0);
        checkOutput("l4_ready", ld_bus.ld_ready, 1);
        checkOutput("l4_hold",  core_hold, 1);
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 8'd0, 0, 1, 32'hA0 + i);
            #1;
            checkOutput("l4_we",    mem_we0, 1);
            checkOutput("l4_waddr", mem_wr_addr0, exp_addr4[i]);
            tick();
            if (load_done) done_cnt++;
            checkOutput("l4_done", load_done, (i == 3) ? 1 : 0);
        end
        applyStimulus(0, 8'd0, 0, 0, 32'h0);
        checkOutput("l4_run_hold", core_hold, 0);
        checkOutput("l4_words",    words_loaded, 4);
        tick();
        if (load_done) done_cnt++;
        checkOutput("l4_done_once", done_cnt, 1);
        checkOutput("l4_nwrites",   wr_addr_q.size(), 4);
        checkOutput("l4_wdata3",    wr_data_q[3], 32'hA3);
        fetchCheck("l4_fetch8", 9'h008, 32'hA2);

        // Three-word load from RUN with a gappy valid.
        applyStimulus(1, 8'd3, 0, 0, 32'h0);
        tick();
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 8'd0, 0, pat_valid[k], 32'hB0 + k);
            #1;
            checkOutput("l3_we", mem_we0, pat_valid[k]);
            tick();
        end
        applyStimulus(0, 8'd0, 0, 0, 32'h0);
        checkOutput("l3_done",    load_done, 1);
        checkOutput("l3_words",   words_loaded, 3);
        checkOutput("l3_nwrites", wr_addr_q.size(), 3);
        checkOutput("l3_addr0",   wr_addr_q[0], 9'h000);
        checkOutput("l3_addr1",   wr_addr_q[1], 9'h004);
        checkOutput("l3_addr2",   wr_addr_q[2], 9'h008);
        checkOutput("l3_data1",   wr_data_q[1], 32'hB3);
        fetchCheck("l3_fetch4", 9'h004, 32'hB3);
        fetchCheck("l3_fetchC", 9'h00C, 32'hA3);

        // Illegal lengths in RUN: error pulse, no state change, no writes.
        wr_addr_q.delete();
        applyStimulus(1, 8'd0, 0, 0, 32'h0);
        tick();
        applyStimulus(0, 8'd0, 0, 0, 32'h0);
        checkOutput("e0_err",   load_err, 1);
        checkOutput("e0_hold",  core_hold, 0);
        checkOutput("e0_ready", ld_bus.ld_ready, 0);
        tick();
        checkOutput("e0_err_clr", load_err, 0);
        applyStimulus(1, 8'd129, 0, 1, 32'h55);
        tick();
        applyStimulus(0, 8'd0, 0, 0, 32'h0);
        checkOutput("e129_err",   load_err, 1);
        checkOutput("e129_hold",  core_hold, 0);
        checkOutput("e129_words", words_loaded, 3);
        tick();
        checkOutput("e129_err_clr", load_err, 0);
        checkOutput("err_nwrites",  wr_addr_q.size(), 0);

        // Reload of two words while running.
        applyStimulus(1, 8'd2, 0, 0, 32'h0);
        #1;
        checkOutput("r2_pre_hold", core_hold, 0);
        tick();
        applyStimulus(0, 8'd0, 0, 0, 32'h0);
        checkOutput("r2_hold", core_hold, 1);
        fetchCheck("r2_nop", 9'h000, 32'h00000013);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 8'd0, 0, 1, 32'hC0 + i);
            tick();
        end
        applyStimulus(0, 8'd0, 0, 0, 32'h0);
        checkOutput("r2_done", load_done, 1);
        checkOutput("r2_run",  core_hold, 0);
        fetchCheck("r2_fetch0", 9'h000, 32'hC0);
        fetchCheck("r2_fetch4", 9'h004, 32'hC1);
        fetchCheck("r2_fetch8", 9'h008, 32'hB5);

        // Reset after two of four words abandons the load but keeps memory.
        applyStimulus(1, 8'd4, 0, 0, 32'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 8'd0, 0, 1, 32'hD0 + i);
            tick();
        end
        applyStimulus(0, 8'd0, 0, 0, 32'h0);
        checkOutput("rs_words_mid", words_loaded, 2);
        checkOutput("rs_ready_mid", ld_bus.ld_ready, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rs_hold",  core_hold, 1);
        checkOutput("rs_ready", ld_bus.ld_ready, 0);
        checkOutput("rs_words", words_loaded, 0);

        // Illegal length with run_go in HOLD: error reported, run_go still honoured.
        applyStimulus(1, 8'd129, 1, 0, 32'h0);
        tick();
        applyStimulus(0, 8'd0, 0, 0, 32'h0);
        checkOutput("hg_err",  load_err, 1);
        checkOutput("hg_hold", core_hold, 0);
        fetchCheck("rs_fetch0", 9'h000, 32'hD0);
        fetchCheck("rs_fetch4", 9'h004, 32'hD1);

        // From HOLD, a legal Depth-long load beats a simultaneous run_go.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1, 8'd128, 1, 0, 32'h0);
        tick();
        applyStimulus(0, 8'd0, 0, 0, 32'h0);
        checkOutput("max_ready", ld_bus.ld_ready, 1);
        checkOutput("max_hold",  core_hold, 1);
        checkOutput("max_err",   load_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
